p2p_port_gate: RTL and testbench

Per-port packet gate for the p2p plugin. It sits between the CMAC-side AXI-Stream ports and the adapter-side ports, one lane per CMAC port. Each lane forwards or discards whole packets under a per-port block control, counts forwarded and dropped packets, and registers the data path for 322 MHz closure. It generalises the single global rx-block behaviour to N ports, a parametrised data width, packet-boundary-safe blocking, backpressure and statistics.

---
 rtl/p2p_pkg.sv | 21 ++
 rtl/p2p_axis_skid.sv | 65 ++++++
 rtl/p2p_port_gate.sv | 145 ++++++++++++++
 tb/tb_p2p_port_gate.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/p2p_pkg.sv
// p2p_pkg: shared types and constants for the p2p port gate.
// Holds the lane FSM state type, keep-width helper and counter ceiling.
package p2p_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } gate_state_t;

    localparam int DATA_W_DEF = 512;
    localparam int KEEP_W = DATA_W_DEF / 8;

    // All-ones ceiling; sliced to the counter width at use.
    localparam logic [63:0] CNT_SAT = '1;

    function automatic int keep_w(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/p2p_axis_skid.sv
// p2p_axis_skid: 2-entry AXI-Stream register slice, registered s_ready.
// Ports: clk, rst_n, s_valid/s_ready/s_data in, m_valid/m_ready/m_data out.
module p2p_axis_skid
    import p2p_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         rdy_q;
    logic         push;
    logic         pop;

    assign push    = s_valid & rdy_q;
    assign pop     = m_valid & m_ready;
    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = mem_q[rd_q];
    assign s_ready = rdy_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Ready is a pure function of next occupancy, so it never
    // depends combinationally on m_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= s_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
        end
    end

endmodule

// File: rtl/p2p_port_gate.sv
// p2p_port_gate: per-lane packet forward/discard gate with packet counters.
// Ports: s_axis_* in, m_axis_* out, block/cnt_clr ctrl, fwd/drop cnt, busy.
module p2p_port_gate
    import p2p_pkg::*;
#(
    parameter int NUM_CMAC_PORT = 2,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int CNT_W         = 32
) (
    input  logic                                 cmac_clk,
    input  logic                                 mod_rstn,
    input  logic [NUM_CMAC_PORT-1:0]             s_axis_tvalid,
    input  logic [NUM_CMAC_PORT-1:0]             s_axis_tlast,
    input  logic [NUM_CMAC_PORT-1:0]             s_axis_tuser_err,
    input  logic [DATA_W*NUM_CMAC_PORT-1:0]      s_axis_tdata,
    input  logic [DATA_W/8*NUM_CMAC_PORT-1:0]    s_axis_tkeep,
    output logic [NUM_CMAC_PORT-1:0]             s_axis_tready,
    output logic [NUM_CMAC_PORT-1:0]             m_axis_tvalid,
    output logic [NUM_CMAC_PORT-1:0]             m_axis_tlast,
    output logic [NUM_CMAC_PORT-1:0]             m_axis_tuser_err,
    output logic [DATA_W*NUM_CMAC_PORT-1:0]      m_axis_tdata,
    output logic [DATA_W/8*NUM_CMAC_PORT-1:0]    m_axis_tkeep,
    input  logic [NUM_CMAC_PORT-1:0]             m_axis_tready,
    input  logic [NUM_CMAC_PORT-1:0]             block,
    input  logic [NUM_CMAC_PORT-1:0]             cnt_clr,
    output logic [CNT_W*NUM_CMAC_PORT-1:0]       pkt_fwd_cnt,
    output logic [CNT_W*NUM_CMAC_PORT-1:0]       pkt_drop_cnt,
    output logic [NUM_CMAC_PORT-1:0]             busy
);

    localparam int KW = keep_w(DATA_W);
    localparam int PW = DATA_W + KW + 2;

    // Clear wins over the old value; a coincident increment lands as 1.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        if (clr) begin
            return inc ? CNT_W'(1) : '0;
        end
        if (inc && (cnt != CNT_SAT[CNT_W-1:0])) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    for (genvar i = 0; i < NUM_CMAC_PORT; i++) begin : g_lane
        gate_state_t      state_q;
        gate_state_t      state_d;
        logic             beat;
        logic             fwd_sel;
        logic             inc_fwd;
        logic             inc_drop;
        logic             sk_ready;
        logic [PW-1:0]    sk_in;
        logic [PW-1:0]    sk_out;
        logic [CNT_W-1:0] fwd_q;
        logic [CNT_W-1:0] drop_q;

        assign beat = s_axis_tvalid[i] & s_axis_tready[i];

        // block only matters on the first beat (IDLE); mid-packet
        // the lane keeps whatever decision that beat made.
        always_comb begin
            state_d  = state_q;
            fwd_sel  = 1'b0;
            inc_fwd  = 1'b0;
            inc_drop = 1'b0;
            unique case (state_q)
                IDLE: begin
                    fwd_sel = ~block[i];
                    if (beat) begin
                        if (s_axis_tlast[i]) begin
                            inc_fwd  = ~block[i];
                            inc_drop = block[i];
                        end else begin
                            state_d = block[i] ? DROP : PASS;
                        end
                    end
                end
                PASS: begin
                    fwd_sel = 1'b1;
                    if (beat && s_axis_tlast[i]) begin
                        state_d = IDLE;
                        inc_fwd = 1'b1;
                    end
                end
                DROP: begin
                    if (beat && s_axis_tlast[i]) begin
                        state_d  = IDLE;
                        inc_drop = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge cmac_clk or negedge mod_rstn) begin
            if (!mod_rstn) begin
                state_q <= IDLE;
                fwd_q   <= '0;
                drop_q  <= '0;
            end else begin
                state_q <= state_d;
                fwd_q   <= cnt_next(fwd_q, inc_fwd, cnt_clr[i]);
                drop_q  <= cnt_next(drop_q, inc_drop, cnt_clr[i]);
            end
        end

        assign sk_in = {
            s_axis_tuser_err[i],
            s_axis_tlast[i],
            s_axis_tkeep[KW*i +: KW],
            s_axis_tdata[DATA_W*i +: DATA_W]
        };

        p2p_axis_skid #(
            .W (PW)
        ) u_skid (
            .clk     (cmac_clk),
            .rst_n   (mod_rstn),
            .s_valid (s_axis_tvalid[i] & fwd_sel),
            .s_ready (sk_ready),
            .s_data  (sk_in),
            .m_valid (m_axis_tvalid[i]),
            .m_ready (m_axis_tready[i]),
            .m_data  (sk_out)
        );

        // Discards sink at line rate independent of the output side.
        assign s_axis_tready[i] = (state_q == DROP) | sk_ready;

        assign m_axis_tdata[DATA_W*i +: DATA_W] = sk_out[DATA_W-1:0];
        assign m_axis_tkeep[KW*i +: KW]         = sk_out[DATA_W +: KW];
        assign m_axis_tlast[i]                  = sk_out[PW-2];
        assign m_axis_tuser_err[i]              = sk_out[PW-1];

        assign pkt_fwd_cnt[CNT_W*i +: CNT_W]  = fwd_q;
        assign pkt_drop_cnt[CNT_W*i +: CNT_W] = drop_q;
        assign busy[i]                        = (state_q != IDLE);
    end

endmodule

// File: tb/tb_p2p_port_gate.sv
// tb_p2p_port_gate: directed bench for p2p_port_gate, 2 lanes, 4-bit counters.
// Table-driven lane 0 vectors plus hand sequences for multi-cycle cases.
module tb_p2p_port_gate;

    localparam int N  = 2;
    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int CW = 4;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    s_valid = '0, s_last = '0, s_err = '0;
    logic [N-1:0]    m_ready = '0, blk = '0, clr = '0;
    logic [N-1:0]    s_ready, m_valid, m_last, m_err, busy;
    logic [DW*N-1:0] s_data = '0, m_data;
    logic [KW*N-1:0] s_keep = '1, m_keep;
    logic [CW*N-1:0] fcnt, dcnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    p2p_port_gate #(
        .NUM_CMAC_PORT (N),
        .DATA_W        (DW),
        .CNT_W         (CW)
    ) dut (
        .cmac_clk         (clk),
        .mod_rstn         (rstn),
        .s_axis_tvalid    (s_valid),
        .s_axis_tlast     (s_last),
        .s_axis_tuser_err (s_err),
        .s_axis_tdata     (s_data),
        .s_axis_tkeep     (s_keep),
        .s_axis_tready    (s_ready),
        .m_axis_tvalid    (m_valid),
        .m_axis_tlast     (m_last),
        .m_axis_tuser_err (m_err),
        .m_axis_tdata     (m_data),
        .m_axis_tkeep     (m_keep),
        .m_axis_tready    (m_ready),
        .block            (blk),
        .cnt_clr          (clr),
        .pkt_fwd_cnt      (fcnt),
        .pkt_drop_cnt     (dcnt),
        .busy             (busy)
    );

    typedef struct {
        logic        blk, vld, lst, err;
        logic [31:0] dat;
        logic        mv, ml, me, bsy;
        logic [31:0] md;
        logic [3:0]  fc, dc;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic b, v, l, e, input logic [31:0] d,
        input logic mv, ml, me, bs, input logic [31:0] md,
        input logic [3:0] fc, dc);
        vec_t r;
        r.blk = b;  r.vld = v;  r.lst = l;  r.err = e;  r.dat = d;
        r.mv = mv;  r.ml = ml;  r.me = me;  r.bsy = bs; r.md = md;
        r.fc = fc;  r.dc = dc;
        return r;
    endfunction

    int          idx;
    logic        acc;
    logic [31:0] rx[$];
    logic [31:0] got;

    initial begin
        // blk vld lst err dat | mv ml me bsy md fwd drop
        tv[0] = mk(0, 1, 1, 0, 32'h01, 1, 1, 0, 0, 32'h01, 1, 0);
        tv[1] = mk(0, 0, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00, 1, 0);
        tv[2] = mk(0, 1, 0, 0, 32'h10, 1, 0, 0, 1, 32'h10, 1, 0);
        tv[3] = mk(0, 1, 0, 0, 32'h11, 1, 0, 0, 1, 32'h11, 1, 0);
        tv[4] = mk(1, 1, 0, 0, 32'h12, 1, 0, 0, 1, 32'h12, 1, 0);
        tv[5] = mk(1, 1, 1, 0, 32'h13, 1, 1, 0, 0, 32'h13, 2, 0);
        tv[6] = mk(1, 1, 0, 0, 32'h20, 0, 0, 0, 1, 32'h00, 2, 0);
        tv[7] = mk(0, 1, 1, 0, 32'h21, 0, 0, 0, 0, 32'h00, 2, 1);
        tv[8] = mk(0, 1, 1, 1, 32'h30, 1, 1, 1, 0, 32'h30, 3, 1);
        tv[9] = mk(0, 0, 0, 0, 32'h00, 0, 0, 0, 0, 32'h00, 3, 1);

        // Reset state.
        repeat (2) tick();
        chk("rst_mvalid", 64'(m_valid), 64'h0);
        chk("rst_sready", 64'(s_ready), 64'h0);
        chk("rst_busy",   64'(busy),    64'h0);
        chk("rst_fcnt",   64'(fcnt),    64'h0);
        chk("rst_dcnt",   64'(dcnt),    64'h0);
        chk("rst_mdata",  m_data[63:0], 64'h0);
        chk("rst_mlast",  64'(m_last),  64'h0);
        #2 rstn = 1'b1;
        tick();
        chk("rel_sready", 64'(s_ready), 64'h3);

        // Lane 0 table: forward, mid-packet block, drop, errored packet.
        m_ready = 2'b11;
        for (int i = 0; i < 10; i++) begin
            blk[0]       = tv[i].blk;
            s_valid[0]   = tv[i].vld;
            s_last[0]    = tv[i].lst;
            s_err[0]     = tv[i].err;
            s_data[31:0] = tv[i].dat;
            tick();
            chk($sformatf("t%0d_mv", i), 64'(m_valid[0]), 64'(tv[i].mv));
            chk($sformatf("t%0d_bsy", i), 64'(busy[0]), 64'(tv[i].bsy));
            chk($sformatf("t%0d_srdy", i), 64'(s_ready[0]), 64'h1);
            chk($sformatf("t%0d_fc", i), 64'(fcnt[3:0]), 64'(tv[i].fc));
            chk($sformatf("t%0d_dc", i), 64'(dcnt[3:0]), 64'(tv[i].dc));
            if (tv[i].mv) begin
                chk($sformatf("t%0d_md", i), m_data[63:0], 64'(tv[i].md));
                chk($sformatf("t%0d_ml", i), 64'(m_last[0]), 64'(tv[i].ml));
                chk($sformatf("t%0d_me", i), 64'(m_err[0]), 64'(tv[i].me));
                chk($sformatf("t%0d_mk", i), m_keep[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
            end
        end
        blk = '0;

        // Lane 1 dropped with downstream stalled; lane 0 forwards alongside.
        blk     = 2'b10;
        m_ready = 2'b01;
        for (int c = 0; c < 3; c++) begin
            s_valid          = {1'b1, c == 0};
            s_last           = {c == 2, 1'b1};
            s_err            = '0;
            s_data[31:0]     = 32'h55;
            s_data[DW +: 32] = 32'h60 + 32'(c);
            tick();
            chk($sformatf("d%0d_srdy1", c), 64'(s_ready[1]), 64'h1);
            chk($sformatf("d%0d_mv1", c), 64'(m_valid[1]), 64'h0);
            chk($sformatf("d%0d_bsy1", c), 64'(busy[1]), 64'(c != 2));
            if (c == 0) begin
                chk("d_lane0_mv", 64'(m_valid[0]), 64'h1);
                chk("d_lane0_md", m_data[63:0], 64'h55);
                chk("d_lane0_fc", 64'(fcnt[3:0]), 64'h4);
            end
        end
        chk("d_drop1", 64'(dcnt[7:4]), 64'h1);
        chk("d_fwd1",  64'(fcnt[7:4]), 64'h0);
        s_valid = '0;
        blk     = '0;
        m_ready = 2'b11;
        tick();

        // 8-beat burst on lane 0 with 5 stalled output cycles.
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            m_ready[0]   = (c >= 5);
            s_valid[0]   = (idx < 8);
            s_last[0]    = (idx == 7);
            s_data[31:0] = 32'h40 + 32'(idx);
            @(negedge clk);
            acc = s_valid[0] & s_ready[0];
            if (m_valid[0] && m_ready[0]) rx.push_back(m_data[31:0]);
            tick();
            if (acc) idx++;
            if (c == 0) chk("bp_rdy_one", 64'(s_ready[0]), 64'h1);
            if (c == 1) chk("bp_rdy_full", 64'(s_ready[0]), 64'h0);
            if (c >= 1 && c <= 4) chk($sformatf("bp_hold%0d", c), m_data[63:0], 64'h40);
        end
        s_valid = '0;
        chk("bp_count", 64'(rx.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            got = (k < rx.size()) ? rx[k] : 32'hDEAD;
            chk($sformatf("bp_beat%0d", k), 64'(got), 64'h40 + 64'(k));
        end
        chk("bp_fwd0", 64'(fcnt[3:0]), 64'h5);

        // Lane 1 counter saturation, then clear with and without increment.
        m_ready = 2'b11;
        s_valid = 2'b10;
        s_last  = 2'b10;
        repeat (16) tick();
        chk("sat_fwd1", 64'(fcnt[7:4]), 64'hF);
        clr = 2'b10;
        tick();
        chk("clr_inc_fwd1", 64'(fcnt[7:4]), 64'h1);
        chk("clr_drop1",    64'(dcnt[7:4]), 64'h0);
        chk("clr_lane0",    64'(fcnt[3:0]), 64'h5);
        s_valid = '0;
        tick();
        chk("clr_only_fwd1", 64'(fcnt[7:4]), 64'h0);
        clr = '0;

        // Reset mid-packet on lane 0.
        m_ready      = 2'b00;
        s_valid      = 2'b01;
        s_last       = 2'b00;
        s_data[31:0] = 32'h77;
        tick();
        chk("mp_busy", 64'(busy[0]), 64'h1);
        chk("mp_mv",   64'(m_valid[0]), 64'h1);
        s_valid = '0;
        #2 rstn = 1'b0;
        #1;
        chk("mp_rst_mv",   64'(m_valid), 64'h0);
        chk("mp_rst_srdy", 64'(s_ready), 64'h0);
        chk("mp_rst_busy", 64'(busy),    64'h0);
        chk("mp_rst_fcnt", 64'(fcnt),    64'h0);
        chk("mp_rst_md",   m_data[63:0], 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("mp_rel_srdy", 64'(s_ready), 64'h3);
        m_ready      = 2'b11;
        s_valid      = 2'b01;
        s_last       = 2'b01;
        s_data[31:0] = 32'h88;
        tick();
        chk("mp_post_mv",  64'(m_valid[0]), 64'h1);
        chk("mp_post_md",  m_data[63:0], 64'h88);
        chk("mp_post_ml",  64'(m_last[0]), 64'h1);
        chk("mp_post_fc",  64'(fcnt[3:0]), 64'h1);
        s_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
